// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU control codes,
// FSM state encoding and the result-class decode of a control code.
package alu_share_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LSW = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_BEQ = 4'b1000;
    localparam logic [3:0] ALU_SLT = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // How a finished operation reports back: the ALU result word, only the
    // equality flag, or nothing at all for codes the ALU does not define.
    typedef enum logic [1:0] {
        RK_DATA = 2'b00,
        RK_ZERO = 2'b01,
        RK_NONE = 2'b10
    } res_kind_e;

    function automatic res_kind_e ctrl_kind(input logic [3:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_LSW, ALU_SLL,
            ALU_AND, ALU_NOR, ALU_SLT: return RK_DATA;
            ALU_BEQ:                   return RK_ZERO;
            default:                   return RK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two ALU requesters, the result
// consumer and the sharing controller.
interface alu_share_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_in1;
    logic [WIDTH-1:0]  req0_in2;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_in1;
    logic [WIDTH-1:0]  req1_in2;
    logic [CTRL_W-1:0] req1_ctrl;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_zero;

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_in1, req1_in2, req1_ctrl,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_in1, req1_in2, req1_ctrl,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_zero,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the valids while enabled,
// with the most recent winner remembered so ties alternate.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to port 1 so that port 0 wins the very first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between the execute stage (port 0)
// and the branch/address unit (port 1): accept, execute, respond.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_ctrl_if.slave   bus,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero
);

    state_e            state, state_nxt;
    logic [1:0]        grant;
    logic              accept;
    logic              rsp_valid;

    logic [WIDTH-1:0]  op_in1, op_in2;
    logic [CTRL_W-1:0] op_ctrl;
    logic              op_id;

    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_zero_q;
    logic              rsp_id_q;

    logic [WIDTH-1:0]  res_data;
    logic              res_zero;
    res_kind_e         res_kind;

    // Grant only while idle and out of reset, so ready never rises early.
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    ((state == ST_IDLE) && !reset),
        .valid ({bus.req1_valid, bus.req0_valid}),
        .grant (grant)
    );

    assign accept = |grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Codes wider than the 4-bit ALU set are never defined operations.
    assign res_kind = ((op_ctrl >> 4) == '0) ? ctrl_kind(op_ctrl[3:0]) : RK_NONE;

    always_comb begin
        res_data = '0;
        res_zero = 1'b0;
        case (res_kind)
            RK_DATA: res_data = alu_out;
            RK_ZERO: res_zero = alu_zero;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_in1     <= '0;
            op_in2     <= '0;
            op_ctrl    <= '0;
            op_id      <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_in1  <= grant[1] ? bus.req1_in1  : bus.req0_in1;
                op_in2  <= grant[1] ? bus.req1_in2  : bus.req0_in2;
                op_ctrl <= grant[1] ? bus.req1_ctrl : bus.req0_ctrl;
                op_id   <= grant[1];
            end
            if (state == ST_EXEC) begin
                rsp_data_q <= res_data;
                rsp_zero_q <= res_zero;
                rsp_id_q   <= op_id;
            end
        end
    end

    assign alu_in1  = op_in1;
    assign alu_in2  = op_in2;
    assign alu_ctrl = op_ctrl;

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU attached.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_share_ctrl_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_share_ctrl #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; undefined codes add so a leaked result would show up.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD, ALU_LSW: alu_out = alu_in1 + alu_in2;
            ALU_SLL:          alu_out = alu_in1 << alu_in2[4:0];
            ALU_AND:          alu_out = alu_in1 & alu_in2;
            ALU_NOR:          alu_out = ~(alu_in1 | alu_in2);
            ALU_SLT:          alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            ALU_BEQ:          alu_out = alu_in1 - alu_in2;
            default:          alu_out = alu_in1 + alu_in2;
        endcase
        alu_zero = (alu_out == 32'b0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0)
                chk("unexpected_rsp", 64'd1, 64'd0);
            else
                chk("rsp", {31'b0, bus.rsp_id, bus.rsp_data, bus.rsp_zero}, {31'b0, sb.pop_front()});
        end
    end

    task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_in1 = a; bus.req0_in2 = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_in1 = a; bus.req1_in2 = b;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_ready(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed, input logic ez);
        bit ok;
        set_req(p, c, a, b);
        wait_ready(p, ok);
        if (ok) sb.push_back('{id: p[0], data: ed, zero: ez});
        @(posedge clk); #1;
        clr_req(p);
    endtask

    task automatic wait_rsp_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_in1 = '0; bus.req0_in2 = '0; bus.req0_ctrl = '0;
        bus.req1_valid = 1'b0; bus.req1_in1 = '0; bus.req1_in2 = '0; bus.req1_ctrl = '0;
        bus.rsp_ready  = 1'b1;

        @(negedge clk);
        chk("reset_ready", {62'b0, bus.req1_ready, bus.req0_ready}, 64'd0);
        chk("reset_rsp", {30'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_data}, 64'd0);
        chk("reset_alu", {28'b0, alu_ctrl, alu_in1}, 64'd0);
        chk("reset_alu_in2", {32'b0, alu_in2}, 64'd0);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // single req0 add with latency checks
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        wait_ready(0, ok);
        if (ok) sb.push_back('{id: 1'b0, data: 32'd12, zero: 1'b0});
        @(posedge clk); #1;
        clr_req(0);
        @(negedge clk);
        chk("exec_alu_drive", {alu_ctrl, alu_in1, 28'b0}, {ALU_ADD, 32'd5, 28'b0});
        chk("exec_in2", {32'b0, alu_in2}, 64'd7);
        chk("exec_no_rsp", {62'b0, bus.rsp_valid, bus.req0_ready}, 64'd0);
        @(negedge clk);
        chk("rsp_latency", {63'b0, bus.rsp_valid}, 64'd1);
        @(posedge clk); #1;

        // beq on port 1, equal and unequal
        issue(1, ALU_BEQ, 32'h1234, 32'h1234, 32'd0, 1'b1);
        wait_rsp_done();
        issue(1, ALU_BEQ, 32'h1234, 32'h1235, 32'd0, 1'b0);
        wait_rsp_done();

        // continuous tie: grants alternate starting with port 0
        set_req(0, ALU_AND, 32'hF0F0, 32'h0FF0);
        set_req(1, ALU_SLT, 32'd3, 32'd9);
        for (int k = 0; k < 6; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin ok = 1'b1; break; end
            end
            if (!ok) chk("tie_timeout", 64'd0, 64'd1);
            chk($sformatf("tie_grant_%0d", k), {62'b0, bus.req1_ready, bus.req0_ready},
                (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k % 2 == 0) sb.push_back('{id: 1'b0, data: 32'h0000_00F0, zero: 1'b0});
            else            sb.push_back('{id: 1'b1, data: 32'd1,          zero: 1'b0});
            @(posedge clk); #1;
            if (k == 5) begin clr_req(0); clr_req(1); end
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("tie_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // backpressure: response held, no accept while a request waits
        bus.rsp_ready = 1'b0;
        issue(0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0);
        set_req(1, ALU_ADD, 32'd10, 32'd20);
        @(negedge clk);
        chk("bp_exec_ready", {63'b0, bus.req1_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", i),
                {27'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.req0_ready, bus.req1_ready, bus.rsp_data},
                {27'b0, 5'b10000, 32'd3});
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_no_accept", {63'b0, bus.req1_ready}, 64'd0);
        @(negedge clk);
        chk("bp_idle_next", {63'b0, bus.req1_ready}, 64'd1);
        if (bus.req1_ready) sb.push_back('{id: 1'b1, data: 32'd30, zero: 1'b0});
        @(posedge clk); #1;
        clr_req(1);
        wait_rsp_done();

        // undefined control code
        issue(0, 4'b0110, 32'd1, 32'd1, 32'd0, 1'b0);
        wait_rsp_done();

        // reset with an operation in EXEC: dropped, outputs back to reset values
        set_req(0, ALU_ADD, 32'd5, 32'd6);
        wait_ready(0, ok);
        @(posedge clk); #1;
        clr_req(0);
        reset = 1'b1;
        #1;
        chk("rst_exec_rsp", {30'b0, bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_data}, 64'd0);
        chk("rst_exec_alu", {28'b0, alu_ctrl, alu_in1}, 64'd0);
        chk("rst_exec_in2", {30'b0, bus.req0_ready, bus.req1_ready, alu_in2}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_rsp", {63'b0, bus.rsp_valid}, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        issue(0, ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
        wait_rsp_done();

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
